// File: rtl/red_pitaya_na_sweep_block.sv
// Network-analyzer sweep sequencer: steps the IQ block frequency, waits for averaging,
// and queues {index, I sum, Q sum} per point in a first-word-fall-through result FIFO.
module red_pitaya_na_sweep_block #(
    parameter int PHASEBITS = 32,
    parameter int SUMBITS   = 62,
    parameter int IDXBITS   = 16,
    parameter int FIFOAW    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [PHASEBITS-1:0] start_freq_i,
    input  logic [PHASEBITS-1:0] step_freq_i,
    input  logic [IDXBITS-1:0]   points_i,
    input  logic                 avg_busy_i,
    input  logic [SUMBITS-1:0]   i_sum_i,
    input  logic [SUMBITS-1:0]   q_sum_i,
    output logic [PHASEBITS-1:0] freq_o,
    output logic                 freq_we_o,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 rd_i,
    output logic                 res_valid_o,
    output logic [SUMBITS-1:0]   res_i_o,
    output logic [SUMBITS-1:0]   res_q_o,
    output logic [IDXBITS-1:0]   res_idx_o,
    output logic [FIFOAW:0]      fifo_count_o
);

    localparam int DEPTH = 1 << FIFOAW;

    typedef enum logic [2:0] {IDLE, SET, HOLD, WAIT, STORE, NEXT} state_t;

    state_t               state_q, state_d;
    logic [PHASEBITS-1:0] freq_q, step_q;
    logic [IDXBITS-1:0]   points_q, idx_q;
    logic                 hold_q;
    logic                 done_q, done_d;
    logic                 load, advance;

    logic [IDXBITS-1:0]   mem_idx [DEPTH];
    logic [SUMBITS-1:0]   mem_i   [DEPTH];
    logic [SUMBITS-1:0]   mem_q   [DEPTH];
    logic [FIFOAW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFOAW:0]      count_q;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_full  = count_q[FIFOAW];
    assign fifo_empty = (count_q == '0);
    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign push = (state_q == STORE) && !abort_i && (!fifo_full || rd_i);
    assign pop  = rd_i && !fifo_empty;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    if (points_i != '0) begin
                        state_d = SET;
                        load    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SET:   state_d = HOLD;
            HOLD:  if (hold_q) state_d = WAIT;
            WAIT:  if (!avg_busy_i) state_d = STORE;
            STORE: if (push) state_d = NEXT;
            NEXT: begin
                if (idx_q == points_q - IDXBITS'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SET;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b1;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            step_q   <= '0;
            points_q <= '0;
            idx_q    <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hold_q  <= (state_q == HOLD) ? ~hold_q : 1'b0;
            if (load) begin
                freq_q   <= start_freq_i;
                step_q   <= step_freq_i;
                points_q <= points_i;
                idx_q    <= '0;
            end else if (advance) begin
                freq_q <= freq_q + step_q;
                idx_q  <= idx_q + IDXBITS'(1);
            end
        end
    end

    // Storage array carries no reset; empty entries are masked at the outputs
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_idx[wr_ptr_q] <= idx_q;
            mem_i[wr_ptr_q]   <= i_sum_i;
            mem_q[wr_ptr_q]   <= q_sum_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFOAW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFOAW'(1);
            if (push && !pop)      count_q <= count_q + (FIFOAW+1)'(1);
            else if (pop && !push) count_q <= count_q - (FIFOAW+1)'(1);
        end
    end

    assign freq_o       = freq_q;
    assign freq_we_o    = (state_q == SET);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign res_valid_o  = !fifo_empty;
    assign fifo_count_o = count_q;
    assign res_idx_o    = fifo_empty ? '0 : mem_idx[rd_ptr_q];
    assign res_i_o      = fifo_empty ? '0 : mem_i[rd_ptr_q];
    assign res_q_o      = fifo_empty ? '0 : mem_q[rd_ptr_q];

endmodule
